// File: rtl/fht_input_loader_if.sv
// Sample stream into fht_input_loader: one real sample per valid/ready transfer.
interface fht_input_loader_if #(
   parameter int D_BIT = 16
) ();
   logic             iVALID;
   logic [D_BIT-1:0] iDATA;
   logic             oREADY;

   modport master (output iVALID, output iDATA, input  oREADY);
   modport slave  (input  iVALID, input  iDATA, output oREADY);
endinterface

// File: rtl/fht_input_loader.sv
// Loads one N-point frame into the 4-bank FHT working RAM in bit-reversed order, then launches fht_control.
// Optional macro FHT_LOADER_DROP_EN: accept and discard samples while the transform runs (adds oDROP_CNT).
module fht_input_loader #(
   parameter int D_BIT = 16,
   parameter int A_BIT = 8,
   parameter int N_BIT = 10
) (
   input  logic              iCLK_2,
   input  logic              iRESET,
   fht_input_loader_if.slave s_in,
   input  logic              iFHT_RDY,
   output logic              oSTART,
   output logic [3:0]        oWE_BANK,
   output logic [A_BIT-1:0]  oADDR_WR,
   output logic [D_BIT-1:0]  oDATA_WR,
   output logic              oBUSY,
   output logic [N_BIT-1:0]  oSAMPLE_CNT
`ifdef FHT_LOADER_DROP_EN
   ,
   output logic [15:0]       oDROP_CNT
`endif
);

   typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE} state_t;

   localparam logic [N_BIT-1:0] LAST_IDX = '1;
`ifdef FHT_LOADER_DROP_EN
   localparam logic WAIT_READY = 1'b1;
`else
   localparam logic WAIT_READY = 1'b0;
`endif

   state_t           state_reg;
   logic             start_phase_reg;
   logic [1:0]       retry_cnt_reg;
   logic             ready_reg;
   logic             start_reg;
   logic             busy_reg;
   logic [3:0]       we_reg;
   logic [A_BIT-1:0] addr_reg;
   logic [D_BIT-1:0] data_reg;
   logic [N_BIT-1:0] cnt_reg;
   logic [N_BIT-1:0] rev_idx;
   logic             xfer;
   logic             accept;

   genvar gi;
   generate
      for (gi = 0; gi < N_BIT; gi++) begin : g_bitrev
         assign rev_idx[gi] = cnt_reg[N_BIT-1-gi];
      end
   endgenerate

   assign xfer   = s_in.iVALID & ready_reg;
   assign accept = xfer & ((state_reg == IDLE) | (state_reg == LOAD));

   always_ff @(posedge iCLK_2 or negedge iRESET) begin
      if (!iRESET) begin
         state_reg       <= IDLE;
         start_phase_reg <= 1'b0;
         retry_cnt_reg   <= '0;
         ready_reg       <= 1'b0;
         start_reg       <= 1'b0;
         busy_reg        <= 1'b0;
         we_reg          <= '0;
         addr_reg        <= '0;
         data_reg        <= '0;
         cnt_reg         <= '0;
      end else begin
         we_reg    <= '0;
         start_reg <= 1'b0;
         if (accept) begin
            we_reg   <= 4'b0001 << rev_idx[1:0];
            addr_reg <= rev_idx[N_BIT-1:2];
            data_reg <= s_in.iDATA;
            cnt_reg  <= cnt_reg + 1'b1;
         end
         case (state_reg)
            IDLE: begin
               ready_reg <= iFHT_RDY;
               if (xfer) begin
                  state_reg <= LOAD;
                  ready_reg <= 1'b1;
                  busy_reg  <= 1'b1;
               end
            end
            LOAD: begin
               if (xfer && cnt_reg == LAST_IDX) begin
                  state_reg       <= START;
                  ready_reg       <= 1'b0;
                  start_phase_reg <= 1'b0;
               end
            end
            START: begin
               // First cycle lets the final bank write land; the pulse goes out in the second.
               if (!start_phase_reg) begin
                  start_phase_reg <= 1'b1;
                  start_reg       <= 1'b1;
               end else begin
                  state_reg     <= WAIT_BUSY;
                  retry_cnt_reg <= '0;
                  ready_reg     <= WAIT_READY;
               end
            end
            WAIT_BUSY: begin
               if (!iFHT_RDY) begin
                  state_reg <= WAIT_DONE;
               end else begin
                  retry_cnt_reg <= retry_cnt_reg + 1'b1;
                  if (retry_cnt_reg == 2'd3) start_reg <= 1'b1;
               end
            end
            WAIT_DONE: begin
               if (iFHT_RDY) begin
                  state_reg <= IDLE;
                  ready_reg <= 1'b1;
                  busy_reg  <= 1'b0;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

`ifdef FHT_LOADER_DROP_EN
   logic [15:0] drop_cnt_reg;

   always_ff @(posedge iCLK_2 or negedge iRESET) begin
      if (!iRESET) begin
         drop_cnt_reg <= '0;
      end else if (xfer && (state_reg == WAIT_BUSY || state_reg == WAIT_DONE)
                   && drop_cnt_reg != 16'hFFFF) begin
         drop_cnt_reg <= drop_cnt_reg + 16'd1;
      end
   end

   assign oDROP_CNT = drop_cnt_reg;
`endif

   assign s_in.oREADY = ready_reg;
   assign oSTART      = start_reg;
   assign oWE_BANK    = we_reg;
   assign oADDR_WR    = addr_reg;
   assign oDATA_WR    = data_reg;
   assign oBUSY       = busy_reg;
   assign oSAMPLE_CNT = cnt_reg;

endmodule
